game_clock_scheduler: RTL and testbench

- Owns game time and schedules professor (quiz) events for the game-state FSM.
- Divides `Clk` into minute ticks and drives the 8-bit `minutes` bus.
- Raises and holds `professor` every `PROF_PERIOD` minutes until the FSM acknowledges it, then enforces a quiz deadline.
- Sits between the board clock and the game-state FSM; the FSM consumes `minutes`, `professor`, `quiz_timeout` and `time_up`.

---
 rtl/game_clock_scheduler_if.sv | 36 +++
 rtl/game_clock_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_game_clock_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_clock_scheduler_if.sv
// game_clock_scheduler_if
//   Bundles the signals exchanged between the game clock scheduler and the
//   game-state FSM. The scheduler uses the slave modport. The FSM (or a
//   testbench) uses the master modport.
//   FSM -> scheduler : Start, Ack, pause, prof_ack, quiz_done
//   scheduler -> FSM : minutes[7:0], min_tick, professor, quiz_timeout,
//                      time_up, q_IDLE/q_RUN/q_PROF_PEND/q_QUIZ/q_DONE
interface game_clock_scheduler_if;
  logic       Start;
  logic       Ack;
  logic       pause;
  logic       prof_ack;
  logic       quiz_done;
  logic [7:0] minutes;
  logic       min_tick;
  logic       professor;
  logic       quiz_timeout;
  logic       time_up;
  logic       q_IDLE;
  logic       q_RUN;
  logic       q_PROF_PEND;
  logic       q_QUIZ;
  logic       q_DONE;

  modport master (
    output Start, Ack, pause, prof_ack, quiz_done,
    input  minutes, min_tick, professor, quiz_timeout, time_up,
    input  q_IDLE, q_RUN, q_PROF_PEND, q_QUIZ, q_DONE
  );

  modport slave (
    input  Start, Ack, pause, prof_ack, quiz_done,
    output minutes, min_tick, professor, quiz_timeout, time_up,
    output q_IDLE, q_RUN, q_PROF_PEND, q_QUIZ, q_DONE
  );
endinterface

// File: rtl/game_clock_scheduler.sv
// game_clock_scheduler
//   Owns game time. It divides Clk into game minutes and schedules professor
//   (quiz) events for the game-state FSM. A quiz deadline is enforced once
//   the FSM acknowledges a professor event.
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of game_clock_scheduler_if (control inputs from the
//             FSM; minutes, pulses, levels and one-hot state decodes back)
//   All outputs are registered.
module game_clock_scheduler #(
  parameter int unsigned TICKS_PER_MIN = 100_000_000,
  parameter int unsigned MAX_TIME      = 120,
  parameter int unsigned PROF_PERIOD   = 16,
  parameter int unsigned QUIZ_WINDOW   = 10
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  game_clock_scheduler_if.slave bus
);

  localparam int unsigned PW  = $clog2(TICKS_PER_MIN);
  localparam int unsigned PCW = (PROF_PERIOD > 1) ? $clog2(PROF_PERIOD) : 1;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [PCW-1:0] PROF_LAST  = PCW'(PROF_PERIOD - 1);
  localparam logic [7:0]     MAX_MIN    = 8'(MAX_TIME);
  localparam logic [8:0]     QWIN       = 9'(QUIZ_WINDOW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PROF_PEND,
    S_QUIZ,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     minutes_q, minutes_d;
  logic [PCW-1:0] prof_cnt_q, prof_cnt_d;
  logic [8:0]     deadline_q, deadline_d;
  logic           min_tick_q, min_tick_d;
  logic           quiz_timeout_q, quiz_timeout_d;
  logic           professor_q, professor_d;
  logic           time_up_q, time_up_d;
  logic           q_idle_q, q_idle_d;
  logic           q_run_q, q_run_d;
  logic           q_prof_q, q_prof_d;
  logic           q_quiz_q, q_quiz_d;
  logic           q_done_q, q_done_d;

  logic counting;
  logic wrap;
  logic at_max;
  logic expired;

  assign counting = (state_q inside {S_RUN, S_PROF_PEND, S_QUIZ}) && !bus.pause;
  assign wrap     = counting && (presc_q == PRESC_LAST);
  assign at_max   = (minutes_q >= MAX_MIN);
  assign expired  = ({1'b0, minutes_q} >= deadline_q);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.Start) state_d = S_RUN;
      S_RUN: begin
        if (at_max)                                 state_d = S_DONE;
        else if (wrap && (prof_cnt_q == PROF_LAST)) state_d = S_PROF_PEND;
      end
      S_PROF_PEND: begin
        if (bus.prof_ack) state_d = S_QUIZ;
        else if (at_max)  state_d = S_DONE;
      end
      S_QUIZ:      if (bus.quiz_done || expired) state_d = S_RUN;
      S_DONE:      if (bus.Ack) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath next values (prescaler, minutes, schedule counter, deadline)
  always_comb begin
    presc_d        = presc_q;
    minutes_d      = minutes_q;
    prof_cnt_d     = prof_cnt_q;
    deadline_d     = deadline_q;
    min_tick_d     = wrap;
    quiz_timeout_d = (state_q == S_QUIZ) && !bus.quiz_done && expired;

    if (counting) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end
    if (wrap && (minutes_q != '1)) begin
      minutes_d = minutes_q + 1'b1;
    end

    if (state_q == S_RUN) begin
      if (state_d == S_PROF_PEND) begin
        prof_cnt_d = '0;
      end else if (state_d == S_RUN && wrap) begin
        prof_cnt_d = prof_cnt_q + 1'b1;
      end
    end
    if (state_q == S_QUIZ && state_d == S_RUN) begin
      prof_cnt_d = '0;
    end
    if (state_q == S_PROF_PEND && state_d == S_QUIZ) begin
      deadline_d = {1'b0, minutes_q} + QWIN;
    end

    // Covers both holding counters in IDLE and clearing minutes on entry.
    if (state_d == S_IDLE) begin
      presc_d    = '0;
      minutes_d  = '0;
      prof_cnt_d = '0;
      deadline_d = '0;
      min_tick_d = 1'b0;
    end
  end

  // Output logic, decoded from the next state so the registers track state_q
  always_comb begin
    professor_d = (state_d == S_PROF_PEND);
    time_up_d   = (state_d == S_DONE);
    q_idle_d    = (state_d == S_IDLE);
    q_run_d     = (state_d == S_RUN);
    q_prof_d    = (state_d == S_PROF_PEND);
    q_quiz_d    = (state_d == S_QUIZ);
    q_done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q        <= '0;
      minutes_q      <= '0;
      prof_cnt_q     <= '0;
      deadline_q     <= '0;
      min_tick_q     <= 1'b0;
      quiz_timeout_q <= 1'b0;
      professor_q    <= 1'b0;
      time_up_q      <= 1'b0;
      q_idle_q       <= 1'b1;
      q_run_q        <= 1'b0;
      q_prof_q       <= 1'b0;
      q_quiz_q       <= 1'b0;
      q_done_q       <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      minutes_q      <= minutes_d;
      prof_cnt_q     <= prof_cnt_d;
      deadline_q     <= deadline_d;
      min_tick_q     <= min_tick_d;
      quiz_timeout_q <= quiz_timeout_d;
      professor_q    <= professor_d;
      time_up_q      <= time_up_d;
      q_idle_q       <= q_idle_d;
      q_run_q        <= q_run_d;
      q_prof_q       <= q_prof_d;
      q_quiz_q       <= q_quiz_d;
      q_done_q       <= q_done_d;
    end
  end

  assign bus.minutes      = minutes_q;
  assign bus.min_tick     = min_tick_q;
  assign bus.professor    = professor_q;
  assign bus.quiz_timeout = quiz_timeout_q;
  assign bus.time_up      = time_up_q;
  assign bus.q_IDLE       = q_idle_q;
  assign bus.q_RUN        = q_run_q;
  assign bus.q_PROF_PEND  = q_prof_q;
  assign bus.q_QUIZ       = q_quiz_q;
  assign bus.q_DONE       = q_done_q;

endmodule

// File: tb/tb_game_clock_scheduler.sv
// tb_game_clock_scheduler
//   Directed bench for game_clock_scheduler with TICKS_PER_MIN=4,
//   MAX_TIME=40, PROF_PERIOD=16, QUIZ_WINDOW=3. The stimulus queues the
//   expected event sequence of each run. A negedge monitor pops and
//   compares each observed event (tick, professor rise, quiz entry,
//   timeout, run entry, done, idle).
module tb_game_clock_scheduler;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  always #5 Clk = ~Clk;

  game_clock_scheduler_if bus ();

  game_clock_scheduler #(
    .TICKS_PER_MIN(4),
    .MAX_TIME(40),
    .PROF_PERIOD(16),
    .QUIZ_WINDOW(3)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  typedef enum int {EV_TICK, EV_PROF, EV_QUIZ, EV_TMO, EV_RUN, EV_DONE, EV_IDLE} ev_e;
  typedef struct {
    ev_e kind;
    int  mins;
    int  gap;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void push(input ev_e k, input int m, input int g);
    ev_t e;
    e.kind = k;
    e.mins = m;
    e.gap  = g;
    exp_q.push_back(e);
  endfunction

  // Ticks first..last; gap 0 means the spacing of that tick is not checked.
  function automatic void push_ticks(input int first, input int last, input int first_gap);
    for (int m = first; m <= last; m++) push(EV_TICK, m, (m == first) ? first_gap : 4);
  endfunction

  task automatic see(input ev_e k, input int m, input int g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %s@%0d expected none at %0t", k.name(), m, $time);
    end else begin
      e = exp_q.pop_front();
      if (k != e.kind || m != e.mins) begin
        errors++;
        $display("FAIL event got %s@%0d expected %s@%0d at %0t",
                 k.name(), m, e.kind.name(), e.mins, $time);
      end
      if (k == EV_TICK && e.kind == EV_TICK && e.gap != 0) chk("tick_gap", g, e.gap);
    end
  endtask

  // Monitor
  logic p_prof = 1'b0, p_quiz = 1'b0, p_run = 1'b0, p_done = 1'b0, p_idle = 1'b1;
  int   gap_cnt = 0;

  always @(negedge Clk) begin
    gap_cnt++;
    if (bus.min_tick) begin
      see(EV_TICK, int'(bus.minutes), gap_cnt);
      gap_cnt = 0;
    end
    if (bus.professor && !p_prof)  see(EV_PROF, int'(bus.minutes), 0);
    if (bus.q_QUIZ && !p_quiz)     see(EV_QUIZ, int'(bus.minutes), 0);
    if (bus.quiz_timeout)          see(EV_TMO,  int'(bus.minutes), 0);
    if (bus.q_RUN && !p_run)       see(EV_RUN,  int'(bus.minutes), 0);
    if (bus.time_up && !p_done)    see(EV_DONE, int'(bus.minutes), 0);
    if (bus.q_IDLE && !p_idle)     see(EV_IDLE, int'(bus.minutes), 0);
    if (bus.q_IDLE) gap_cnt = 0;
    p_prof = bus.professor;
    p_quiz = bus.q_QUIZ;
    p_run  = bus.q_RUN;
    p_done = bus.time_up;
    p_idle = bus.q_IDLE;
  end

  task automatic wait_tick(input int m);
    bit hit;
    logic [7:0] mm;
    hit = 1'b0;
    mm  = m[7:0];
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge Clk);
      hit = bus.min_tick && (bus.minutes == mm);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_tick timeout actual minutes %0d required tick at %0d", bus.minutes, m);
    end
  endtask

  task automatic start_run();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic ack_done();
    bus.Ack = 1'b1;
    @(negedge Clk);
    bus.Ack = 1'b0;
  endtask

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog actual running required finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bus.Start = 1'b0;
    bus.Ack = 1'b0;
    bus.pause = 1'b0;
    bus.prof_ack = 1'b0;
    bus.quiz_done = 1'b0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_minutes", int'(bus.minutes), 0);
    chk("rst_min_tick", int'(bus.min_tick), 0);
    chk("rst_professor", int'(bus.professor), 0);
    chk("rst_quiz_timeout", int'(bus.quiz_timeout), 0);
    chk("rst_time_up", int'(bus.time_up), 0);
    chk("rst_q_IDLE", int'(bus.q_IDLE), 1);
    chk("rst_q_others", int'({bus.q_RUN, bus.q_PROF_PEND, bus.q_QUIZ, bus.q_DONE}), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Run 1: start, pause, ignored inputs, ack at 17, done at 18, done at 40
    push(EV_RUN, 0, 0);
    push(EV_TICK, 1, 0);
    push(EV_TICK, 2, 4);
    push(EV_TICK, 3, 14);
    push_ticks(4, 16, 4);
    push(EV_PROF, 16, 0);
    push(EV_TICK, 17, 4);
    push(EV_QUIZ, 17, 0);
    push(EV_TICK, 18, 4);
    push(EV_RUN, 18, 0);
    push_ticks(19, 34, 4);
    push(EV_PROF, 34, 0);
    push_ticks(35, 40, 4);
    push(EV_DONE, 40, 0);
    push(EV_IDLE, 0, 0);

    start_run();
    repeat (3) @(negedge Clk);
    chk("min_before_first_tick", int'(bus.minutes), 0);
    @(negedge Clk);
    chk("min_first_tick", int'(bus.minutes), 1);
    chk("min_tick_high", int'(bus.min_tick), 1);
    @(negedge Clk);
    chk("min_tick_low_next", int'(bus.min_tick), 0);
    wait_tick(2);
    @(negedge Clk);
    bus.pause = 1'b1;
    repeat (10) @(negedge Clk);
    chk("paused_minutes", int'(bus.minutes), 2);
    bus.pause = 1'b0;
    wait_tick(5);
    bus.prof_ack = 1'b1;
    bus.quiz_done = 1'b1;
    bus.Start = 1'b1;
    bus.Ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    bus.quiz_done = 1'b0;
    bus.Start = 1'b0;
    bus.Ack = 1'b0;
    chk("ignored_inputs_run", int'(bus.q_RUN), 1);
    wait_tick(17);
    bus.prof_ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    chk("quiz_entered", int'(bus.q_QUIZ), 1);
    chk("professor_fell", int'(bus.professor), 0);
    wait_tick(18);
    bus.quiz_done = 1'b1;
    @(negedge Clk);
    bus.quiz_done = 1'b0;
    chk("done_back_to_run", int'(bus.q_RUN), 1);
    chk("done_no_timeout", int'(bus.quiz_timeout), 0);
    wait_tick(40);
    @(negedge Clk);
    chk("done_time_up", int'(bus.time_up), 1);
    chk("done_q_DONE", int'(bus.q_DONE), 1);
    bus.pause = 1'b1;
    repeat (10) @(negedge Clk);
    bus.pause = 1'b0;
    chk("done_frozen_minutes", int'(bus.minutes), 40);
    ack_done();
    chk("ack_q_IDLE", int'(bus.q_IDLE), 1);
    chk("ack_minutes_cleared", int'(bus.minutes), 0);
    chk("ack_time_up_low", int'(bus.time_up), 0);

    // Run 2: timeout at 19, then quiz_done on the deadline cycle at 38
    push(EV_RUN, 0, 0);
    push_ticks(1, 16, 0);
    push(EV_PROF, 16, 0);
    push(EV_QUIZ, 16, 0);
    push_ticks(17, 19, 4);
    push(EV_TMO, 19, 0);
    push(EV_RUN, 19, 0);
    push_ticks(20, 35, 4);
    push(EV_PROF, 35, 0);
    push(EV_QUIZ, 35, 0);
    push_ticks(36, 38, 4);
    push(EV_RUN, 38, 0);
    push_ticks(39, 40, 4);
    push(EV_DONE, 40, 0);
    push(EV_IDLE, 0, 0);

    start_run();
    wait_tick(16);
    chk("prof_rise_at_16", int'(bus.professor), 1);
    bus.prof_ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    wait_tick(19);
    @(negedge Clk);
    chk("timeout_pulse", int'(bus.quiz_timeout), 1);
    chk("timeout_q_RUN", int'(bus.q_RUN), 1);
    @(negedge Clk);
    chk("timeout_single_cycle", int'(bus.quiz_timeout), 0);
    wait_tick(35);
    bus.prof_ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    wait_tick(38);
    bus.quiz_done = 1'b1;
    @(negedge Clk);
    bus.quiz_done = 1'b0;
    chk("deadline_done_wins", int'(bus.quiz_timeout), 0);
    chk("deadline_done_run", int'(bus.q_RUN), 1);
    wait_tick(40);
    @(negedge Clk);
    chk("run2_done", int'(bus.q_DONE), 1);
    ack_done();

    // Run 3: professor pending past MAX_TIME, ack on the MAX_TIME cycle
    push(EV_RUN, 0, 0);
    push_ticks(1, 16, 0);
    push(EV_PROF, 16, 0);
    push_ticks(17, 40, 4);
    push(EV_QUIZ, 40, 0);
    push_ticks(41, 43, 4);
    push(EV_TMO, 43, 0);
    push(EV_RUN, 43, 0);
    push(EV_DONE, 43, 0);
    push(EV_IDLE, 0, 0);

    start_run();
    wait_tick(40);
    chk("pending_at_max", int'(bus.professor), 1);
    bus.prof_ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    chk("ack_beats_max", int'(bus.q_QUIZ), 1);
    chk("ack_beats_max_no_done", int'(bus.time_up), 0);
    wait_tick(43);
    @(negedge Clk);
    chk("late_timeout", int'(bus.quiz_timeout), 1);
    @(negedge Clk);
    chk("late_done", int'(bus.time_up), 1);
    chk("late_done_minutes", int'(bus.minutes), 43);
    ack_done();

    // Run 4: asynchronous reset in the middle of a quiz
    push(EV_RUN, 0, 0);
    push_ticks(1, 16, 0);
    push(EV_PROF, 16, 0);
    push(EV_QUIZ, 16, 0);
    push(EV_TICK, 17, 4);
    push(EV_IDLE, 0, 0);

    start_run();
    wait_tick(16);
    bus.prof_ack = 1'b1;
    @(negedge Clk);
    bus.prof_ack = 1'b0;
    wait_tick(17);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midquiz_rst_q_IDLE", int'(bus.q_IDLE), 1);
    chk("midquiz_rst_q_QUIZ", int'(bus.q_QUIZ), 0);
    chk("midquiz_rst_professor", int'(bus.professor), 0);
    chk("midquiz_rst_minutes", int'(bus.minutes), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    chk("expected_events_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
